// File: rtl/state_trace_fifo_pkg.sv
// Shared widths and defaults for the state trace FIFO.
package state_trace_fifo_pkg;

  localparam int ST_W        = 3;
  localparam int DWELL_W_DEF = 8;
  localparam int DEPTH_DEF   = 8;
  localparam int ENTRY_W_DEF = ST_W + DWELL_W_DEF;

endpackage : state_trace_fifo_pkg

// File: rtl/trace_fifo_core.sv
// First-word-fall-through FIFO with occupancy count; full/empty come from the count.
module trace_fifo_core #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == CNT_W'(0));
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_pop_s  = pop_i & ~empty_o;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign do_push_s = push_i & (~full_o | do_pop_s);
  assign count_o   = count_q;
  assign rdata_o   = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!clear_i && do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule : trace_fifo_core

// File: rtl/state_trace_fifo.sv
// Records each completed upstream state with the number of sampled cycles it lasted.
module state_trace_fifo
  import state_trace_fifo_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ST_W-1:0]          st_in,
  input  logic                     st_en,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [ST_W-1:0]          rd_state,
  output logic [DWELL_W-1:0]       rd_dwell,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int ENTRY_W = ST_W + DWELL_W;

  logic [ST_W-1:0]    last_state_q, last_state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               primed_q, primed_d;
  logic               overflow_q, overflow_d;
  logic               push_s, pop_s, full_s, empty_s;
  logic [ENTRY_W-1:0] rdata_s;

  assign push_s   = st_en & primed_q & (st_in != last_state_q);
  assign pop_s    = ~empty_s & rd_ready;
  assign rd_valid = ~empty_s;
  assign rd_state = rdata_s[ENTRY_W-1:DWELL_W];
  assign rd_dwell = rdata_s[DWELL_W-1:0];
  assign overflow = overflow_q;

  trace_fifo_core #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear),
    .push_i  (push_s),
    .pop_i   (rd_ready),
    .wdata_i ({last_state_q, dwell_q}),
    .rdata_o (rdata_s),
    .count_o (count),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  always_comb begin
    last_state_d = last_state_q;
    dwell_d      = dwell_q;
    primed_d     = primed_q;
    overflow_d   = overflow_q;
    if (clear) begin
      last_state_d = '0;
      dwell_d      = '0;
      primed_d     = 1'b0;
      overflow_d   = 1'b0;
    end else begin
      if (st_en) begin
        if (!primed_q || (st_in != last_state_q)) begin
          last_state_d = st_in;
          dwell_d      = DWELL_W'(1);
          primed_d     = 1'b1;
        end else if (dwell_q != '1) begin
          dwell_d = dwell_q + DWELL_W'(1);
        end else begin
          dwell_d = dwell_q;
        end
      end else begin
        dwell_d = dwell_q;
      end
      // A rejected push is the only way an entry is lost.
      if (push_s && full_s && !pop_s) overflow_d = 1'b1;
      else                            overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_state_q <= '0;
      dwell_q      <= '0;
      primed_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      last_state_q <= last_state_d;
      dwell_q      <= dwell_d;
      primed_q     <= primed_d;
      overflow_q   <= overflow_d;
    end
  end

endmodule : state_trace_fifo
